// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: the carry chain is split into STAGES segments, one register per segment.
// Latency is STAGES cycles; the whole pipe freezes whenever the output holds a beat and ready_i is low.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
`ifdef USE_POWER_PINS
  inout  wire               VPWR,
  inout  wire               VGND,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic              sub_i,
  input  logic              carry_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  sum_o,
  output logic              carry_o,
  output logic              overflow_o
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic advance;

  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    // a_in/b_in hold only the operand bits not yet consumed; this stage's segment sits at the bottom.
    logic [REM-1:0]      a_in;
    logic [REM-1:0]      b_in;
    logic                c_in;
    logic                v_in;
    logic [SEG:0]        seg_sum;
    logic [LO+SEG-1:0]   res_d;
    logic [LO+SEG-1:0]   res_q;
    logic                c_q;
    logic                v_q;

    if (k == 0) begin : g_first
      assign a_in  = a_i;
      assign b_in  = b_i ^ {WIDTH{sub_i}};
      assign c_in  = carry_i ^ sub_i;
      assign v_in  = valid_i;
      assign res_d = seg_sum[SEG-1:0];
    end else begin : g_next
      assign a_in  = g_stage[k-1].g_skew.a_q;
      assign b_in  = g_stage[k-1].g_skew.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign res_d = {seg_sum[SEG-1:0], g_stage[k-1].res_q};
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        if (v_in) begin
          c_q   <= seg_sum[SEG];
          res_q <= res_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      // Both operand MSBs are still present here because the MSB lives in the final segment.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance && v_in) begin
          ovf_q <= (a_in[REM-1] == b_in[REM-1]) && (seg_sum[SEG-1] != a_in[REM-1]);
        end
      end
    end else begin : g_skew
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      always_ff @(posedge clk) begin
        if (advance && v_in) begin
          a_q <= a_in[REM-1:SEG];
          b_q <= b_in[REM-1:SEG];
        end
      end
    end
  end

  assign valid_o    = g_stage[STAGES-1].v_q;
  assign sum_o      = g_stage[STAGES-1].res_q;
  assign carry_o    = g_stage[STAGES-1].c_q;
  assign overflow_o = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and randomised checks of pipelined_addsub at 8/2, 16/4 and 8/1.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vi[3];
  logic        ri[3];
  logic        subi[3];
  logic        ci[3];
  logic [15:0] ai[3];
  logic [15:0] bi[3];
  logic        vo[3];
  logic        ro[3];
  logic        co[3];
  logic        oo[3];
  logic [15:0] so[3];
  logic [7:0]  s8_0;
  logic [7:0]  s8_2;
  logic [15:0] s16_1;

  assign so[0] = {8'h00, s8_0};
  assign so[1] = s16_1;
  assign so[2] = {8'h00, s8_2};

`ifdef USE_POWER_PINS
  wire vpwr = 1'b1;
  wire vgnd = 1'b0;
`endif

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_d0 (
`ifdef USE_POWER_PINS
    .VPWR(vpwr), .VGND(vgnd),
`endif
    .clk(clk), .rst(rst), .valid_i(vi[0]), .ready_o(ro[0]), .a_i(ai[0][7:0]), .b_i(bi[0][7:0]),
    .sub_i(subi[0]), .carry_i(ci[0]), .valid_o(vo[0]), .ready_i(ri[0]), .sum_o(s8_0),
    .carry_o(co[0]), .overflow_o(oo[0]));

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_d1 (
`ifdef USE_POWER_PINS
    .VPWR(vpwr), .VGND(vgnd),
`endif
    .clk(clk), .rst(rst), .valid_i(vi[1]), .ready_o(ro[1]), .a_i(ai[1]), .b_i(bi[1]),
    .sub_i(subi[1]), .carry_i(ci[1]), .valid_o(vo[1]), .ready_i(ri[1]), .sum_o(s16_1),
    .carry_o(co[1]), .overflow_o(oo[1]));

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_d2 (
`ifdef USE_POWER_PINS
    .VPWR(vpwr), .VGND(vgnd),
`endif
    .clk(clk), .rst(rst), .valid_i(vi[2]), .ready_o(ro[2]), .a_i(ai[2][7:0]), .b_i(bi[2][7:0]),
    .sub_i(subi[2]), .carry_i(ci[2]), .valid_o(vo[2]), .ready_i(ri[2]), .sum_o(s8_2),
    .carry_o(co[2]), .overflow_o(oo[2]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: full-width add of a, b' and effective carry, then truncate to w bits.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic c, input int w);
    logic [16:0] full;
    logic [15:0] mask;
    logic [15:0] bb;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    mask = 16'((32'd1 << w) - 1);
    bb   = s ? (~b & mask) : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? !c : c)};
    sum  = full[15:0] & mask;
    cout = full[w];
    ovf  = (a[w-1] == bb[w-1]) && (sum[w-1] != a[w-1]);
    return {ovf, cout, sum};
  endfunction

  // One isolated beat on the 8/2 unit, checked at its two-cycle latency.
  task automatic dir_beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic c,
                          input logic [7:0] es, input logic ec, input logic eo);
    ai[0] = {8'h00, a}; bi[0] = {8'h00, b}; subi[0] = s; ci[0] = c;
    vi[0] = 1'b1; ri[0] = 1'b1;
    @(posedge clk); #1;
    vi[0] = 1'b0;
    @(negedge clk);
    chk({tag, "_early_valid"}, vo[0], 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_valid"}, vo[0], 1);
    chk({tag, "_sum"},   so[0], es);
    chk({tag, "_carry"}, co[0], ec);
    chk({tag, "_ovf"},   oo[0], eo);
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int d, input int w, input int n);
    logic [17:0] q[$];
    logic [17:0] e;
    logic [15:0] mask;
    int          sent;
    int          cyc;
    logic        acc;
    mask = 16'((32'd1 << w) - 1);
    sent = 0;
    cyc  = 0;
    vi[d] = 1'b0;
    while ((sent < n || q.size() != 0) && cyc < 40 * n) begin
      if (!vi[d] && sent < n && $urandom_range(3) != 0) begin
        vi[d]   = 1'b1;
        ai[d]   = 16'($urandom) & mask;
        bi[d]   = 16'($urandom) & mask;
        subi[d] = 1'($urandom_range(1));
        ci[d]   = 1'($urandom_range(1));
      end
      ri[d] = ($urandom_range(9) < 7);
      @(negedge clk);
      if (vo[d] && ri[d]) begin
        if (q.size() == 0) begin
          chk("rand_spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rand_sum",   so[d], {16'd0, e[15:0]});
          chk("rand_carry", co[d], e[16]);
          chk("rand_ovf",   oo[d], e[17]);
        end
      end
      acc = vi[d] && ro[d];
      if (acc) begin
        q.push_back(model(ai[d], bi[d], subi[d], ci[d], w));
        sent++;
      end
      @(posedge clk); #1;
      if (acc) vi[d] = 1'b0;
      cyc++;
    end
    chk("rand_outstanding", n - sent + q.size(), 0);
    ri[d] = 1'b1;
  endtask

  int ev[9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  int es[9] = '{0, 0, 2, 2, 2, 4, 6, 8, 0};
  int er[9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
  int beat_idx;
  int retired;
  logic acc0;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vi[d] = 1'b0; ri[d] = 1'b1; subi[d] = 1'b0; ci[d] = 1'b0; ai[d] = '0; bi[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", vo[0], 0);
    chk("rst_sum_o",   so[0], 0);
    chk("rst_carry_o", co[0], 0);
    chk("rst_ovf_o",   oo[0], 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_o", ro[0], 1);

    dir_beat("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    dir_beat("add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    dir_beat("add_0f_cin",  8'h0F, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    dir_beat("sub_10_20",   8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
    dir_beat("sub_80_01",   8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    dir_beat("sub_05_bin",  8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

    // Four back-to-back beats with the output stalled in cycles 2 and 3.
    beat_idx = 0;
    for (int t = 0; t < 9; t++) begin
      ri[0]   = !(t == 2 || t == 3);
      vi[0]   = (beat_idx < 4);
      ai[0]   = 16'(beat_idx + 1);
      bi[0]   = 16'(beat_idx + 1);
      subi[0] = 1'b0;
      ci[0]   = 1'b0;
      @(negedge clk);
      chk($sformatf("bp_ready_t%0d", t), ro[0], er[t]);
      chk($sformatf("bp_valid_t%0d", t), vo[0], ev[t]);
      if (ev[t] != 0) chk($sformatf("bp_sum_t%0d", t), so[0], es[t]);
      acc0 = vi[0] && ro[0];
      @(posedge clk); #1;
      if (acc0) beat_idx++;
    end
    vi[0] = 1'b0;
    chk("bp_beats_accepted", beat_idx, 4);

    // Reset with two beats in flight: nothing may retire, pipe must come back empty.
    retired = 0;
    ri[0] = 1'b0;
    vi[0] = 1'b1; ai[0] = 16'h0011; bi[0] = 16'h0001;
    @(negedge clk);
    if (vo[0] && ri[0]) retired++;
    @(posedge clk); #1;
    ai[0] = 16'h0022; bi[0] = 16'h0002;
    @(negedge clk);
    if (vo[0] && ri[0]) retired++;
    @(posedge clk); #1;
    vi[0] = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    if (vo[0] && ri[0]) retired++;
    @(posedge clk); #1;
    rst   = 1'b0;
    ri[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid_o", vo[0], 0);
    chk("mid_rst_sum_o",   so[0], 0);
    chk("mid_rst_ready_o", ro[0], 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (vo[0] && ri[0]) retired++;
    end
    chk("mid_rst_retired", retired, 0);
    @(posedge clk); #1;
    dir_beat("after_rst", 8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

    rand_run(1, 16, 60);
    rand_run(2, 8, 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
